id_ex_pipeline_register: RTL and testbench

ID_EX_PIPELINE_REGISTER -- requirements
Module: idExPipelineRegister

---
 rtl/id_ex_pipeline_register.sv | 117 +++++++++++
 tb/tb_id_ex_pipeline_register.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_pipeline_register.sv
// ID/EX pipeline register with load-use hazard detection and bubble insertion.
// Holds the decoded instruction for EX and counts the hazard bubbles it inserts.
module id_ex_pipeline_register #(
  parameter int DATA_WIDTH  = 32,
  parameter int COUNT_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   validIn,
  input  logic                   stall,
  input  logic                   flush,
  input  logic                   pcUpdateIn,
  input  logic                   memoryReadEnableIn,
  input  logic                   memoryWriteEnableIn,
  input  logic                   registerWriteEnableIn,
  input  logic                   pcAdderSrcIn,
  input  logic                   writeBackFromAluOrMemoryIn,
  input  logic [1:0]             aluSrc1In,
  input  logic [1:0]             aluSrc2In,
  input  logic [2:0]             aluOperationIn,
  input  logic [DATA_WIDTH-1:0]  pcIn,
  input  logic [DATA_WIDTH-1:0]  rs1DataIn,
  input  logic [DATA_WIDTH-1:0]  rs2DataIn,
  input  logic [DATA_WIDTH-1:0]  immediateIn,
  input  logic [4:0]             rs1In,
  input  logic [4:0]             rs2In,
  input  logic [4:0]             rdIn,
  input  logic                   rs1Used,
  input  logic                   rs2Used,
  output logic                   validOut,
  output logic                   pcUpdateOut,
  output logic                   memoryReadEnableOut,
  output logic                   memoryWriteEnableOut,
  output logic                   registerWriteEnableOut,
  output logic                   pcAdderSrcOut,
  output logic                   writeBackFromAluOrMemoryOut,
  output logic [1:0]             aluSrc1Out,
  output logic [1:0]             aluSrc2Out,
  output logic [2:0]             aluOperationOut,
  output logic [DATA_WIDTH-1:0]  pcOut,
  output logic [DATA_WIDTH-1:0]  rs1DataOut,
  output logic [DATA_WIDTH-1:0]  rs2DataOut,
  output logic [DATA_WIDTH-1:0]  immediateOut,
  output logic [4:0]             rs1Out,
  output logic [4:0]             rs2Out,
  output logic [4:0]             rdOut,
  output logic                   loadUseStall,
  output logic [COUNT_WIDTH-1:0] bubbleCount
);

  logic rs1Match;
  logic rs2Match;
  logic hazard;
  logic killSlot;

  // A load in EX writing a register the decode instruction reads; x0 never hazards.
  assign rs1Match = rs1Used && (rs1In == rdOut);
  assign rs2Match = rs2Used && (rs2In == rdOut);
  assign hazard   = validOut && memoryReadEnableOut && (rdOut != 5'd0) &&
                    validIn && (rs1Match || rs2Match);

  assign loadUseStall = hazard && !flush && !stall;

  // Flush wins over stall; a hazard only bubbles once the stall has released.
  assign killSlot = flush || (hazard && !stall);

  always_ff @(posedge clk) begin
    if (reset || killSlot) begin
      validOut                    <= 1'b0;
      pcUpdateOut                 <= 1'b0;
      memoryReadEnableOut         <= 1'b0;
      memoryWriteEnableOut        <= 1'b0;
      registerWriteEnableOut      <= 1'b0;
      pcAdderSrcOut               <= 1'b0;
      writeBackFromAluOrMemoryOut <= 1'b0;
      aluSrc1Out                  <= '0;
      aluSrc2Out                  <= '0;
      aluOperationOut             <= '0;
      pcOut                       <= '0;
      rs1DataOut                  <= '0;
      rs2DataOut                  <= '0;
      immediateOut                <= '0;
      rs1Out                      <= '0;
      rs2Out                      <= '0;
      rdOut                       <= '0;
    end else if (!stall) begin
      validOut                    <= validIn;
      // An empty decode slot must not leak side-effecting enables into EX.
      pcUpdateOut                 <= pcUpdateIn && validIn;
      memoryReadEnableOut         <= memoryReadEnableIn && validIn;
      memoryWriteEnableOut        <= memoryWriteEnableIn && validIn;
      registerWriteEnableOut      <= registerWriteEnableIn && validIn;
      pcAdderSrcOut               <= pcAdderSrcIn;
      writeBackFromAluOrMemoryOut <= writeBackFromAluOrMemoryIn;
      aluSrc1Out                  <= aluSrc1In;
      aluSrc2Out                  <= aluSrc2In;
      aluOperationOut             <= aluOperationIn;
      pcOut                       <= pcIn;
      rs1DataOut                  <= rs1DataIn;
      rs2DataOut                  <= rs2DataIn;
      immediateOut                <= immediateIn;
      rs1Out                      <= rs1In;
      rs2Out                      <= rs2In;
      rdOut                       <= rdIn;
    end
  end

  // Only hazard bubbles are counted; the counter sticks at all-ones.
  always_ff @(posedge clk) begin
    if (reset) begin
      bubbleCount <= '0;
    end else if (loadUseStall && (bubbleCount != '1)) begin
      bubbleCount <= bubbleCount + COUNT_WIDTH'(1);
    end
  end

endmodule

// File: tb/tb_id_ex_pipeline_register.sv
// Scoreboard bench for id_ex_pipeline_register: a driver issues stimulus and queues the
// modelled response, a monitor compares both a default-width and a 2-bit-counter instance.
module tb_id_ex_pipeline_register;

  typedef struct packed {
    logic        valid;
    logic        pcUpdate;
    logic        memRead;
    logic        memWrite;
    logic        regWrite;
    logic        pcAdderSrc;
    logic        wbSel;
    logic [1:0]  aluSrc1;
    logic [1:0]  aluSrc2;
    logic [2:0]  aluOp;
    logic [31:0] pc;
    logic [31:0] rs1Data;
    logic [31:0] rs2Data;
    logic [31:0] imm;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
  } slot_t;

  typedef struct packed {
    logic  reset;
    logic  flush;
    logic  stall;
    logic  rs1Used;
    logic  rs2Used;
    slot_t f;
  } stim_t;

  typedef struct {
    bit          chkLus;
    bit          lus;
    slot_t       st;
    logic [15:0] cntBig;
    logic [1:0]  cntSmall;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset = 1'b0, validIn = 1'b0, stall = 1'b0, flush = 1'b0;
  logic        pcUpdateIn = 1'b0, memoryReadEnableIn = 1'b0, memoryWriteEnableIn = 1'b0;
  logic        registerWriteEnableIn = 1'b0, pcAdderSrcIn = 1'b0, writeBackFromAluOrMemoryIn = 1'b0;
  logic [1:0]  aluSrc1In = '0, aluSrc2In = '0;
  logic [2:0]  aluOperationIn = '0;
  logic [31:0] pcIn = '0, rs1DataIn = '0, rs2DataIn = '0, immediateIn = '0;
  logic [4:0]  rs1In = '0, rs2In = '0, rdIn = '0;
  logic        rs1Used = 1'b0, rs2Used = 1'b0;

  logic        validOut, pcUpdateOut, memoryReadEnableOut, memoryWriteEnableOut;
  logic        registerWriteEnableOut, pcAdderSrcOut, writeBackFromAluOrMemoryOut;
  logic [1:0]  aluSrc1Out, aluSrc2Out;
  logic [2:0]  aluOperationOut;
  logic [31:0] pcOut, rs1DataOut, rs2DataOut, immediateOut;
  logic [4:0]  rs1Out, rs2Out, rdOut;
  logic        loadUseStall;
  logic [15:0] bubbleCount;

  logic        sValidOut, sPcUpdateOut, sMemoryReadEnableOut, sMemoryWriteEnableOut;
  logic        sRegisterWriteEnableOut, sPcAdderSrcOut, sWriteBackFromAluOrMemoryOut;
  logic [1:0]  sAluSrc1Out, sAluSrc2Out;
  logic [2:0]  sAluOperationOut;
  logic [31:0] sPcOut, sRs1DataOut, sRs2DataOut, sImmediateOut;
  logic [4:0]  sRs1Out, sRs2Out, sRdOut;
  logic        sLoadUseStall;
  logic [1:0]  sBubbleCount;

  id_ex_pipeline_register #(.DATA_WIDTH(32), .COUNT_WIDTH(16)) dut (
    .clk(clk), .reset(reset), .validIn(validIn), .stall(stall), .flush(flush),
    .pcUpdateIn(pcUpdateIn), .memoryReadEnableIn(memoryReadEnableIn),
    .memoryWriteEnableIn(memoryWriteEnableIn), .registerWriteEnableIn(registerWriteEnableIn),
    .pcAdderSrcIn(pcAdderSrcIn), .writeBackFromAluOrMemoryIn(writeBackFromAluOrMemoryIn),
    .aluSrc1In(aluSrc1In), .aluSrc2In(aluSrc2In), .aluOperationIn(aluOperationIn),
    .pcIn(pcIn), .rs1DataIn(rs1DataIn), .rs2DataIn(rs2DataIn), .immediateIn(immediateIn),
    .rs1In(rs1In), .rs2In(rs2In), .rdIn(rdIn), .rs1Used(rs1Used), .rs2Used(rs2Used),
    .validOut(validOut), .pcUpdateOut(pcUpdateOut), .memoryReadEnableOut(memoryReadEnableOut),
    .memoryWriteEnableOut(memoryWriteEnableOut), .registerWriteEnableOut(registerWriteEnableOut),
    .pcAdderSrcOut(pcAdderSrcOut), .writeBackFromAluOrMemoryOut(writeBackFromAluOrMemoryOut),
    .aluSrc1Out(aluSrc1Out), .aluSrc2Out(aluSrc2Out), .aluOperationOut(aluOperationOut),
    .pcOut(pcOut), .rs1DataOut(rs1DataOut), .rs2DataOut(rs2DataOut), .immediateOut(immediateOut),
    .rs1Out(rs1Out), .rs2Out(rs2Out), .rdOut(rdOut),
    .loadUseStall(loadUseStall), .bubbleCount(bubbleCount)
  );

  id_ex_pipeline_register #(.DATA_WIDTH(32), .COUNT_WIDTH(2)) dutSmall (
    .clk(clk), .reset(reset), .validIn(validIn), .stall(stall), .flush(flush),
    .pcUpdateIn(pcUpdateIn), .memoryReadEnableIn(memoryReadEnableIn),
    .memoryWriteEnableIn(memoryWriteEnableIn), .registerWriteEnableIn(registerWriteEnableIn),
    .pcAdderSrcIn(pcAdderSrcIn), .writeBackFromAluOrMemoryIn(writeBackFromAluOrMemoryIn),
    .aluSrc1In(aluSrc1In), .aluSrc2In(aluSrc2In), .aluOperationIn(aluOperationIn),
    .pcIn(pcIn), .rs1DataIn(rs1DataIn), .rs2DataIn(rs2DataIn), .immediateIn(immediateIn),
    .rs1In(rs1In), .rs2In(rs2In), .rdIn(rdIn), .rs1Used(rs1Used), .rs2Used(rs2Used),
    .validOut(sValidOut), .pcUpdateOut(sPcUpdateOut), .memoryReadEnableOut(sMemoryReadEnableOut),
    .memoryWriteEnableOut(sMemoryWriteEnableOut), .registerWriteEnableOut(sRegisterWriteEnableOut),
    .pcAdderSrcOut(sPcAdderSrcOut), .writeBackFromAluOrMemoryOut(sWriteBackFromAluOrMemoryOut),
    .aluSrc1Out(sAluSrc1Out), .aluSrc2Out(sAluSrc2Out), .aluOperationOut(sAluOperationOut),
    .pcOut(sPcOut), .rs1DataOut(sRs1DataOut), .rs2DataOut(sRs2DataOut), .immediateOut(sImmediateOut),
    .rs1Out(sRs1Out), .rs2Out(sRs2Out), .rdOut(sRdOut),
    .loadUseStall(sLoadUseStall), .bubbleCount(sBubbleCount)
  );

  slot_t dutSt;
  assign dutSt = {validOut, pcUpdateOut, memoryReadEnableOut, memoryWriteEnableOut,
                  registerWriteEnableOut, pcAdderSrcOut, writeBackFromAluOrMemoryOut,
                  aluSrc1Out, aluSrc2Out, aluOperationOut, pcOut, rs1DataOut, rs2DataOut,
                  immediateOut, rs1Out, rs2Out, rdOut};

  exp_t        sbq[$];
  int          errors = 0;
  int          checks = 0;
  bit          driverDone = 1'b0;

  // Reference model: what EX should hold and how many hazard bubbles have occurred.
  slot_t       mState = '0;
  int unsigned mBubbles = 0;

  function automatic stim_t idleStim();
    stim_t s;
    s = '0;
    return s;
  endfunction

  function automatic stim_t randStim();
    stim_t s;
    s            = '0;
    s.reset      = ($urandom_range(0, 99) < 3);
    s.flush      = ($urandom_range(0, 99) < 8);
    s.stall      = ($urandom_range(0, 99) < 20);
    s.rs1Used    = 1'($urandom_range(0, 1));
    s.rs2Used    = 1'($urandom_range(0, 1));
    s.f.valid    = ($urandom_range(0, 99) < 80);
    s.f.pcUpdate = 1'($urandom_range(0, 1));
    s.f.memRead  = 1'($urandom_range(0, 1));
    s.f.memWrite = 1'($urandom_range(0, 1));
    s.f.regWrite = 1'($urandom_range(0, 1));
    s.f.pcAdderSrc = 1'($urandom_range(0, 1));
    s.f.wbSel    = 1'($urandom_range(0, 1));
    s.f.aluSrc1  = 2'($urandom_range(0, 3));
    s.f.aluSrc2  = 2'($urandom_range(0, 3));
    s.f.aluOp    = 3'($urandom_range(0, 7));
    s.f.pc       = $urandom;
    s.f.rs1Data  = $urandom;
    s.f.rs2Data  = $urandom;
    s.f.imm      = $urandom;
    s.f.rs1      = 5'($urandom_range(0, 3));
    s.f.rs2      = 5'($urandom_range(0, 3));
    s.f.rd       = 5'($urandom_range(0, 3));
    return s;
  endfunction

  // EX-stage image of a decode slot: an empty slot carries no enables.
  function automatic slot_t captured(slot_t f);
    slot_t r;
    r = f;
    if (!f.valid) begin
      r.pcUpdate = 1'b0;
      r.memRead  = 1'b0;
      r.memWrite = 1'b0;
      r.regWrite = 1'b0;
    end
    return r;
  endfunction

  task automatic issue(input stim_t s, input bit chkLus);
    exp_t e;
    bit   readsRd;
    bit   hz;
    @(negedge clk);
    #1;
    readsRd = (s.rs1Used && s.f.rs1 == mState.rd) || (s.rs2Used && s.f.rs2 == mState.rd);
    hz      = mState.valid && mState.memRead && (mState.rd != 0) && s.f.valid && readsRd;
    e.chkLus = chkLus;
    e.lus    = hz && !s.flush && !s.stall;
    if (s.reset) begin
      mState   = '0;
      mBubbles = 0;
    end else if (s.flush) begin
      mState = '0;
    end else if (s.stall) begin
      mState = mState;
    end else if (hz) begin
      mState   = '0;
      mBubbles = mBubbles + 1;
    end else begin
      mState = captured(s.f);
    end
    e.st       = mState;
    e.cntBig   = (mBubbles > 65535) ? 16'hFFFF : 16'(mBubbles);
    e.cntSmall = (mBubbles > 3) ? 2'd3 : 2'(mBubbles);
    sbq.push_back(e);

    reset = s.reset; flush = s.flush; stall = s.stall;
    rs1Used = s.rs1Used; rs2Used = s.rs2Used;
    validIn = s.f.valid; pcUpdateIn = s.f.pcUpdate; memoryReadEnableIn = s.f.memRead;
    memoryWriteEnableIn = s.f.memWrite; registerWriteEnableIn = s.f.regWrite;
    pcAdderSrcIn = s.f.pcAdderSrc; writeBackFromAluOrMemoryIn = s.f.wbSel;
    aluSrc1In = s.f.aluSrc1; aluSrc2In = s.f.aluSrc2; aluOperationIn = s.f.aluOp;
    pcIn = s.f.pc; rs1DataIn = s.f.rs1Data; rs2DataIn = s.f.rs2Data; immediateIn = s.f.imm;
    rs1In = s.f.rs1; rs2In = s.f.rs2; rdIn = s.f.rd;
  endtask

  // Monitor: loadUseStall is checked mid-cycle, registered state one tick after the edge.
  initial begin : monitor
    exp_t e;
    int   txn;
    txn = 0;
    forever begin
      @(negedge clk);
      #3;
      if (sbq.size() > 0) begin
        e = sbq[0];
        if (e.chkLus) begin
          checks++;
          if (loadUseStall !== e.lus) begin
            errors++;
            $display("FAIL loadUseStall txn %0d: got %b expected %b", txn, loadUseStall, e.lus);
          end
          checks++;
          if (sLoadUseStall !== e.lus) begin
            errors++;
            $display("FAIL loadUseStallSmall txn %0d: got %b expected %b", txn, sLoadUseStall, e.lus);
          end
        end
        @(posedge clk);
        #1;
        void'(sbq.pop_front());
        checks++;
        if (dutSt !== e.st) begin
          errors++;
          $display("FAIL exSlot txn %0d: got %h expected %h", txn, dutSt, e.st);
        end
        checks++;
        if (bubbleCount !== e.cntBig) begin
          errors++;
          $display("FAIL bubbleCount txn %0d: got %0d expected %0d", txn, bubbleCount, e.cntBig);
        end
        checks++;
        if (sBubbleCount !== e.cntSmall) begin
          errors++;
          $display("FAIL bubbleCountSmall txn %0d: got %0d expected %0d", txn, sBubbleCount, e.cntSmall);
        end
        $display("txn %0d: valid=%b rd=%0d lus=%b count=%0d small=%0d", txn, validOut, rdOut,
                 e.lus, bubbleCount, sBubbleCount);
        txn++;
      end
    end
  end

  initial begin : driver
    stim_t s, ld, dec;

    // Reset held two cycles with every input high.
    s = '1;
    issue(s, 1'b0);
    issue(s, 1'b1);
    issue(idleStim(), 1'b1);

    // Pass-through.
    s = idleStim();
    s.f.valid = 1'b1; s.f.rd = 5'd5; s.f.aluOp = 3'b011; s.f.imm = 32'h10;
    issue(s, 1'b1);

    // Load-use: bubble, then the held decode instruction is captured.
    ld = idleStim();
    ld.f.valid = 1'b1; ld.f.memRead = 1'b1; ld.f.regWrite = 1'b1; ld.f.rd = 5'd7;
    ld.f.rs1 = 5'd1; ld.f.rs2 = 5'd2;
    dec = idleStim();
    dec.f.valid = 1'b1; dec.f.rs1 = 5'd7; dec.rs1Used = 1'b1; dec.f.rd = 5'd9;
    dec.f.aluOp = 3'b101; dec.f.pc = 32'h100;
    issue(ld, 1'b1);
    issue(dec, 1'b1);
    issue(dec, 1'b1);

    // No hazard: source unused, then load targeting x0.
    issue(ld, 1'b1);
    s = dec; s.rs1Used = 1'b0;
    issue(s, 1'b1);
    s = ld; s.f.rd = 5'd0;
    issue(s, 1'b1);
    s = dec; s.f.rs1 = 5'd0;
    issue(s, 1'b1);

    // Flush beats stall and hazard.
    issue(ld, 1'b1);
    s = dec; s.flush = 1'b1; s.stall = 1'b1;
    issue(s, 1'b1);

    // Stall across a hazard keeps the load; bubble on stall release.
    issue(ld, 1'b1);
    s = dec; s.stall = 1'b1;
    issue(s, 1'b1);
    issue(s, 1'b1);
    issue(dec, 1'b1);
    issue(dec, 1'b1);

    // Reset mid-stall discards the held load; next edge loads normally.
    issue(ld, 1'b1);
    s = dec; s.stall = 1'b1;
    issue(s, 1'b1);
    s.reset = 1'b1;
    issue(s, 1'b1);
    issue(dec, 1'b1);

    // Five hazard bubbles: the 2-bit counter steps 1,2,3,3,3.
    for (int i = 0; i < 5; i++) begin
      issue(ld, 1'b1);
      issue(dec, 1'b1);
    end

    for (int i = 0; i < 400; i++) begin
      issue(randStim(), 1'b1);
    end
    issue(idleStim(), 1'b1);

    driverDone = 1'b1;
    repeat (5) @(posedge clk);
    #2;
    checks++;
    if (sbq.size() != 0) begin
      errors++;
      $display("FAIL scoreboardDrain: got %0d pending expected 0", sbq.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
